// File: rtl/seq_divider_pkg.sv
// seq_divider shared types.
// FSM state encodings for the restoring divider.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_if.sv
// seq_divider request/result bundle.
// master drives operands, slave returns results.
interface seq_divider_if #(
  parameter int WIDTH = 8
) ();

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start,
    output dividend,
    output divisor,
    input  busy,
    input  done,
    input  quotient,
    input  remainder,
    input  div_by_zero
  );

  modport slave (
    input  start,
    input  dividend,
    input  divisor,
    output busy,
    output done,
    output quotient,
    output remainder,
    output div_by_zero
  );

endinterface

// File: rtl/seq_divider_sub_nbit.sv
// sub_nbit: N-bit ripple subtractor.
// diff = a - b, borrow set when a < b.
module sub_nbit #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);

  logic [N:0] bw;

  assign bw[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign diff[i]  = a[i] ^ b[i] ^ bw[i];
    assign bw[i+1]  = (~a[i] & b[i])
                    | (~(a[i] ^ b[i]) & bw[i]);
  end

  assign borrow = bw[N];

endmodule

// File: rtl/seq_divider.sv
// seq_divider: unsigned restoring divider.
// One quotient bit per cycle, MSB first.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  seq_divider_if.slave      bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvs;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;

  // quo starts as the dividend; its MSB is the next bit to bring down
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial_b;
  logic [WIDTH:0]   diff;
  logic             borrow;

  assign shifted = {rem, quo[WIDTH-1]};
  assign trial_b = {1'b0, dvs};

  sub_nbit #(
    .N(WIDTH + 1)
  ) u_sub (
    .a      (shifted),
    .b      (trial_b),
    .diff   (diff),
    .borrow (borrow)
  );

  // Divider FSM, shift registers and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      quo    <= '0;
      rem    <= '0;
      dvs    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.divisor != '0) begin
              quo    <= bus.dividend;
              dvs    <= bus.divisor;
              rem    <= '0;
              dbz_q  <= 1'b0;
              cnt    <= CW'(WIDTH - 1);
              busy_q <= 1'b1;
              state  <= CALC;
            end else begin
              quo    <= '1;
              rem    <= bus.dividend;
              dbz_q  <= 1'b1;
              done_q <= 1'b1;
              state  <= DONE;
            end
          end
        end
        CALC: begin
          rem <= borrow ? shifted[WIDTH-1:0]
                        : diff[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], ~borrow};
          if (cnt == '0) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quo;
  assign bus.remainder   = rem;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed checks of seq_divider.
// Cycle n is the clock period that ends at edge n.
module tb_seq_divider;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  seq_divider_if #(.WIDTH(8)) bus ();

  seq_divider #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one operation; returns results, done cycle
  // (1 = cycle after accept edge), busy count, anomalies.
  task automatic run_op(
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] q,
    output logic [7:0] r,
    output logic       z,
    output int         lat,
    output int         nbusy,
    output int         extra
  );
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    tick();
    bus.start    = 1'b0;
    bus.dividend = 8'($urandom);
    bus.divisor  = 8'($urandom);
    lat   = -1;
    nbusy = 0;
    extra = 0;
    for (int c = 1; c <= 20; c++) begin
      if (bus.done) begin
        lat = c;
        break;
      end
      if (bus.busy) nbusy++;
      tick();
    end
    q = bus.quotient;
    r = bus.remainder;
    z = bus.div_by_zero;
    if (bus.busy) extra++;
    tick();
    if (bus.done) extra++;
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.dividend = 8'd100;
    bus.divisor  = 8'd7;
    tick();
    tick();
    total++;
    if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags got=%b want=000",
               {bus.busy, bus.done, bus.div_by_zero});
    end
    total++;
    if ({bus.quotient, bus.remainder} !== 16'h0000) begin
      bad++;
      $display("FAIL reset_data got=%h want=0000",
               {bus.quotient, bus.remainder});
    end
    bus.start = 1'b0;
    reset     = 1'b0;
    tick();
  endtask

  task automatic test_basic;
    logic [7:0] q, r;
    logic z;
    int lat, nb, ex;
    run_op(8'd100, 8'd7, q, r, z, lat, nb, ex);
    total++;
    if ({q, r, z} !== {8'd14, 8'd2, 1'b0}) begin
      bad++;
      $display("FAIL basic_result got=%0d r %0d z %0b want=14 r 2 z 0",
               q, r, z);
    end
    total++;
    if (lat !== 9) begin
      bad++;
      $display("FAIL basic_latency got=%0d want=9", lat);
    end
    total++;
    if (nb !== 8 || ex !== 0) begin
      bad++;
      $display("FAIL basic_busy got=busy%0d/anom%0d want=8/0", nb, ex);
    end
  endtask

  task automatic test_vectors;
    logic [7:0] va [3] = '{8'd255, 8'd5, 8'd200};
    logic [7:0] vb [3] = '{8'd1,   8'd9, 8'd200};
    logic [7:0] vq [3] = '{8'd255, 8'd0, 8'd1};
    logic [7:0] vr [3] = '{8'd0,   8'd5, 8'd0};
    logic [7:0] q, r;
    logic z;
    int lat, nb, ex;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], q, r, z, lat, nb, ex);
      total++;
      if ({q, r, z, lat} !== {vq[i], vr[i], 1'b0, 32'sd9}) begin
        bad++;
        $display("FAIL vec_%0d got=%0d r %0d z %0b lat %0d want=%0d r %0d z 0 lat 9",
                 i, q, r, z, lat, vq[i], vr[i]);
      end
    end
  endtask

  task automatic test_div0;
    logic [7:0] q, r;
    logic z;
    int lat, nb, ex;
    run_op(8'd23, 8'd0, q, r, z, lat, nb, ex);
    total++;
    if ({q, r, z} !== {8'd255, 8'd23, 1'b1}) begin
      bad++;
      $display("FAIL div0_result got=%0d r %0d z %0b want=255 r 23 z 1",
               q, r, z);
    end
    total++;
    if (lat !== 1) begin
      bad++;
      $display("FAIL div0_latency got=%0d want=1", lat);
    end
    total++;
    if (nb !== 0 || ex !== 0) begin
      bad++;
      $display("FAIL div0_busy got=busy%0d/anom%0d want=0/0", nb, ex);
    end
  endtask

  task automatic test_restart;
    logic [7:0] q, r;
    logic z;
    int lat, nb, ex;
    int dones = 0;
    logic [7:0] cq = '0;
    logic [7:0] cr = '0;
    bus.start    = 1'b1;
    bus.dividend = 8'd100;
    bus.divisor  = 8'd7;
    tick();
    for (int c = 1; c <= 9; c++) begin
      if (bus.done) begin
        dones++;
        cq = bus.quotient;
        cr = bus.remainder;
      end
      bus.start    = (c == 3 || c == 9);
      bus.dividend = 8'd5;
      bus.divisor  = 8'd9;
      tick();
    end
    bus.start = 1'b0;
    total++;
    if (dones !== 1 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL restart_done_count got=%0d want=1", dones + int'(bus.done));
    end
    total++;
    if ({cq, cr, bus.quotient, bus.remainder}
        !== {8'd14, 8'd2, 8'd14, 8'd2}) begin
      bad++;
      $display("FAIL restart_result got=%0d r %0d held %0d r %0d want=14 r 2",
               cq, cr, bus.quotient, bus.remainder);
    end
    run_op(8'd50, 8'd3, q, r, z, lat, nb, ex);
    total++;
    if ({q, r, z, lat} !== {8'd16, 8'd2, 1'b0, 32'sd9}) begin
      bad++;
      $display("FAIL restart_next got=%0d r %0d lat %0d want=16 r 2 lat 9",
               q, r, lat);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] q, r;
    logic z;
    int lat, nb, ex;
    int dones = 0;
    bus.start    = 1'b1;
    bus.dividend = 8'd100;
    bus.divisor  = 8'd7;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 3; c++) tick();
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL midrst_busy_before got=%b want=1", bus.busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if ({bus.busy, bus.done, bus.div_by_zero,
         bus.quotient, bus.remainder} !== 19'd0) begin
      bad++;
      $display("FAIL midrst_clear got=%b%b%b q %0d r %0d want=all 0",
               bus.busy, bus.done, bus.div_by_zero,
               bus.quotient, bus.remainder);
    end
    for (int c = 0; c < 12; c++) begin
      if (bus.done || bus.busy) dones++;
      tick();
    end
    total++;
    if (dones !== 0) begin
      bad++;
      $display("FAIL midrst_no_done got=%0d want=0", dones);
    end
    run_op(8'd50, 8'd3, q, r, z, lat, nb, ex);
    total++;
    if ({q, r, z, lat} !== {8'd16, 8'd2, 1'b0, 32'sd9}) begin
      bad++;
      $display("FAIL midrst_next got=%0d r %0d lat %0d want=16 r 2 lat 9",
               q, r, lat);
    end
  endtask

  task automatic test_sweep;
    logic [7:0] a, b, q, r, eq, er;
    logic z, ez;
    int lat, nb, ex, elat, enb;
    for (int i = 0; i < 2000; i++) begin
      a = 8'($urandom);
      b = (i % 97 == 0) ? 8'd0 : 8'($urandom);
      if (b == 8'd0) begin
        eq = 8'd255; er = a; ez = 1'b1; elat = 1; enb = 0;
      end else begin
        eq = a / b; er = a % b; ez = 1'b0; elat = 9; enb = 8;
      end
      run_op(a, b, q, r, z, lat, nb, ex);
      total++;
      if ({q, r, z} !== {eq, er, ez}) begin
        bad++;
        $display("FAIL sweep_result %0d/%0d got=%0d r %0d z %0b want=%0d r %0d z %0b",
                 a, b, q, r, z, eq, er, ez);
      end
      total++;
      if (lat !== elat || nb !== enb || ex !== 0) begin
        bad++;
        $display("FAIL sweep_timing %0d/%0d got=lat%0d busy%0d anom%0d want=lat%0d busy%0d anom0",
                 a, b, lat, nb, ex, elat, enb);
      end
    end
  endtask

  initial begin
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    test_reset();
    test_basic();
    test_vectors();
    test_div0();
    test_restart();
    test_reset_mid();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
